// File: rtl/pong_pkg.sv
// Shared pong definitions: playfield geometry, bitmap width and the AI paddle state encoding.
package pong_pkg;

  localparam int ROWS     = 32;
  localparam int BITMAP_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RETURN = 2'd1,
    TRACK  = 2'd2
  } ai_state_t;

  // Resting row for a paddle of the given length: middle of the legal range.
  function automatic int centre_of(input int len);
    return (ROWS - len) / 2;
  endfunction

endpackage

// File: rtl/ai_paddle_if.sv
// Ball-position inputs and paddle outputs exchanged between the game core and the AI paddle.
interface ai_paddle_if;
  import pong_pkg::*;

  logic                enable;
  logic [3:0]          level;
  logic [4:0]          ball_x;
  logic [4:0]          ball_y;
  logic [BITMAP_W-1:0] paddle_o;
  logic [4:0]          pos;

  modport master (output enable, level, ball_x, ball_y, input paddle_o, pos);
  modport slave  (input enable, level, ball_x, ball_y, output paddle_o, pos);

endinterface

// File: rtl/ai_step_timer.sv
// Base step strobe plus the difficulty-scaled move divider for the AI paddle.
module ai_step_timer #(
  parameter int STEP_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] level,
  output logic       step,
  output logic       move
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [3:0]    div_r;
  logic          wrap_s;

  // A divider already past a newly lowered limit still wraps, at 15.
  assign wrap_s = (div_r == (4'd15 - level)) || (div_r == 4'd15);
  assign step   = (cnt_r == STEP_LAST);
  assign move   = step && wrap_s;

  // Free-running step counter and move divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      div_r <= 4'd0;
    end else begin
      if (step) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (step && wrap_s) begin
        div_r <= 4'd0;
      end else if (step) begin
        div_r <= div_r + 4'd1;
      end else begin
        div_r <= div_r;
      end
    end
  end

endmodule

// File: rtl/ai_paddle.sv
// Autonomous paddle: tracks an approaching ball inside a window, otherwise drifts back to centre.
module ai_paddle
  import pong_pkg::*;
#(
  parameter int SIDE       = 0,
  parameter int PADDLE_LEN = 4,
  parameter int STEP_DIV   = 100000,
  parameter int WINDOW     = 20
) (
  input logic        clk,
  input logic        reset,
  ai_paddle_if.slave bus
);

  localparam logic [4:0]          MAXPOS_V = 5'(ROWS - PADDLE_LEN);
  localparam logic [4:0]          CENTRE_V = 5'(centre_of(PADDLE_LEN));
  localparam logic [5:0]          WINDOW_V = 6'(WINDOW);
  localparam logic [5:0]          HALF_V   = 6'(PADDLE_LEN / 2);
  localparam logic [BITMAP_W-1:0] MASK_V   = BITMAP_W'((64'd1 << PADDLE_LEN) - 64'd1);

  ai_state_t        state_r, state_s;
  logic [4:0]       x_q_r, y_q_r, pos_r, pos_s;
  logic             appr_r, appr_s;
  logic             step_s, move_s;
  logic [4:0]       dist_s, y_s, track_tgt_s, target_s;
  logic signed [5:0] ty_s;

  ai_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .level (bus.level),
    .step  (step_s),
    .move  (move_s)
  );

  // Direction, distance and the target row implied by the state being entered.
  always_comb begin
    appr_s      = appr_r;
    dist_s      = (SIDE == 0) ? bus.ball_x : (5'd31 - bus.ball_x);
    y_s         = step_s ? bus.ball_y : y_q_r;
    ty_s        = $signed({1'b0, y_s}) - $signed(HALF_V);
    track_tgt_s = CENTRE_V;
    if ((SIDE == 0) ? (bus.ball_x < x_q_r) : (bus.ball_x > x_q_r)) begin
      appr_s = 1'b1;
    end else if (bus.ball_x != x_q_r) begin
      appr_s = 1'b0;
    end else begin
      appr_s = appr_r;
    end
    if (ty_s[5]) begin
      track_tgt_s = 5'd0;
    end else if (ty_s[4:0] > MAXPOS_V) begin
      track_tgt_s = MAXPOS_V;
    end else begin
      track_tgt_s = ty_s[4:0];
    end
  end

  // Next state (only on step) and one-row motion toward the new state's target.
  always_comb begin
    state_s  = state_r;
    target_s = CENTRE_V;
    pos_s    = pos_r;
    if (!step_s) begin
      state_s = state_r;
    end else if (!bus.enable) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = RETURN;
        RETURN:  state_s = (appr_s && ({1'b0, dist_s} <= WINDOW_V)) ? TRACK : RETURN;
        TRACK:   state_s = appr_s ? TRACK : RETURN;
        default: state_s = IDLE;
      endcase
    end
    if (state_s == TRACK) begin
      target_s = track_tgt_s;
    end else begin
      target_s = CENTRE_V;
    end
    if (move_s && (pos_r < target_s)) begin
      pos_s = pos_r + 5'd1;
    end else if (move_s && (pos_r > target_s)) begin
      pos_s = pos_r - 5'd1;
    end else begin
      pos_s = pos_r;
    end
  end

  // State, ball sample and paddle position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      x_q_r   <= 5'd0;
      y_q_r   <= 5'd0;
      appr_r  <= 1'b0;
      pos_r   <= CENTRE_V;
    end else begin
      if (step_s) begin
        x_q_r  <= bus.ball_x;
        y_q_r  <= bus.ball_y;
        appr_r <= appr_s;
      end else begin
        x_q_r  <= x_q_r;
        y_q_r  <= y_q_r;
        appr_r <= appr_r;
      end
      state_r <= state_s;
      pos_r   <= pos_s;
    end
  end

  assign bus.pos      = pos_r;
  assign bus.paddle_o = MASK_V << pos_r;

endmodule

// File: tb/tb_ai_paddle.sv
// Directed vector bench for ai_paddle with a fast step timer.
module tb_ai_paddle;

  typedef struct {
    logic       en;
    logic [3:0] lvl;
    logic [4:0] bx;
    logic [4:0] by;
    logic [4:0] exp_pos;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  ai_paddle_if bus ();

  ai_paddle #(.STEP_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pos(input string name, input logic [4:0] exp);
    logic [31:0] bm;
    bm = 32'hF << exp;
    chk({name, " pos"}, {27'd0, bus.pos}, {27'd0, exp});
    chk({name, " paddle"}, bus.paddle_o, bm);
  endtask

  function automatic void add(input logic en, input logic [3:0] lvl,
                              input logic [4:0] bx, input logic [4:0] by, input logic [4:0] p);
    vec_t v;
    v.en = en; v.lvl = lvl; v.bx = bx; v.by = by; v.exp_pos = p;
    vecs.push_back(v);
  endfunction

  initial begin
    int exp_i;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.level  = 4'd15;
    bus.ball_x = 5'd0;
    bus.ball_y = 5'd0;

    // Track to the bottom clamp, recede back to centre, window entry, then enable drop.
    add(1'b1, 4'd15, 5'd20, 5'd30, 5'd14);
    add(1'b1, 4'd15, 5'd19, 5'd30, 5'd15);
    add(1'b1, 4'd15, 5'd18, 5'd30, 5'd16);
    for (int p = 17; p <= 28; p++) add(1'b1, 4'd15, 5'd18, 5'd30, 5'(p));
    add(1'b1, 4'd15, 5'd18, 5'd30, 5'd28);
    for (int p = 27; p >= 14; p--) add(1'b1, 4'd15, 5'd19, 5'd30, 5'(p));
    add(1'b1, 4'd15, 5'd19, 5'd30, 5'd14);
    add(1'b1, 4'd15, 5'd26, 5'd22, 5'd14);
    for (int x = 25; x >= 21; x--) add(1'b1, 4'd15, 5'(x), 5'd22, 5'd14);
    add(1'b1, 4'd15, 5'd20, 5'd22, 5'd15);
    for (int p = 16; p <= 20; p++) add(1'b1, 4'd15, 5'd20, 5'd22, 5'(p));
    for (int p = 19; p >= 17; p--) add(1'b0, 4'd15, 5'd20, 5'd22, 5'(p));

    tick(3);
    chk_pos("reset", 5'd14);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_pos("early", 5'd14);
    end
    tick(1);
    chk_pos("first_step", 5'd14);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.enable = vecs[i].en;
      bus.level  = vecs[i].lvl;
      bus.ball_x = vecs[i].bx;
      bus.ball_y = vecs[i].by;
      tick(4);
      chk_pos($sformatf("vec%0d", i), vecs[i].exp_pos);
    end

    // Reset lands on the edge that would have moved pos 17 -> 16.
    tick(3);
    reset = 1'b1;
    tick(1);
    chk_pos("midmove_reset", 5'd14);
    reset = 1'b0;

    // Slowest level: one row every 16 steps down to the top clamp.
    bus.enable = 1'b1;
    bus.level  = 4'd0;
    bus.ball_y = 5'd0;
    for (int s = 1; s <= 240; s++) begin
      bus.ball_x = (s == 1) ? 5'd20 : 5'd19;
      tick(4);
      exp_i = 14 - (s / 16);
      if (exp_i < 0) exp_i = 0;
      chk_pos($sformatf("slow%0d", s), 5'(exp_i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
